// File: rtl/nac_mem_read_arbiter.sv
// Round-robin arbiter sharing one AXI read port among NUM_REQ burst requesters.
// Issues AR bursts, tracks outstanding bursts in order and steers R beats back.
module nac_mem_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int MAX_OUTST = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ*8-1:0]      req_len_i,
  input  logic [NUM_REQ-1:0]        flush_i,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic [NUM_REQ-1:0]        valid_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic [ADDR_W-1:0]         m_araddr,
  output logic [7:0]                m_arlen,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_W-1:0]         m_rdata,
  input  logic                      m_rvalid,
  input  logic                      m_rlast,
  output logic                      m_rready,
  output logic                      err_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  logic [NUM_REQ-1:0]             r_pend;
  logic [NUM_REQ-1:0][ADDR_W-1:0] r_paddr;
  logic [NUM_REQ-1:0][7:0]        r_plen;
  logic [IW-1:0]                  r_rr_ptr;
  logic [MAX_OUTST-1:0][IW-1:0]   r_tag_id;
  logic [MAX_OUTST-1:0][7:0]      r_tag_len;
  logic [MAX_OUTST-1:0]           r_tag_disc;
  logic [PW-1:0]                  r_wr_ptr;
  logic [PW-1:0]                  r_rd_ptr;
  logic [CW-1:0]                  r_outst;
  logic [8:0]                     r_beat_cnt;

  logic          w_grant;
  logic [IW-1:0] w_win;
  logic          w_beat;
  logic          w_has_tag;
  logic          w_pop;
  logic [IW-1:0] w_head_id;
  logic [7:0]    w_head_len;
  logic          w_head_disc;

  // Winner is the first pending requester at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx     = 0;
    w_grant = 1'b0;
    w_win   = '0;
    if ((!m_arvalid || m_arready) && (r_outst < CW'(MAX_OUTST))) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(r_rr_ptr) + k) % NUM_REQ;
        if (!w_grant && r_pend[idx]) begin
          w_grant = 1'b1;
          w_win   = IW'(idx);
        end
      end
    end
  end

  assign w_head_id   = r_tag_id[r_rd_ptr];
  assign w_head_len  = r_tag_len[r_rd_ptr];
  assign w_head_disc = r_tag_disc[r_rd_ptr];
  assign w_beat      = m_rvalid && m_rready;
  assign w_has_tag   = (r_outst != '0);
  assign w_pop       = w_beat && w_has_tag && m_rlast;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (flush_i[i])
          r_pend[i] <= 1'b0;
        else if (w_grant && (w_win == IW'(i)))
          r_pend[i] <= 1'b0;
        else if (req_i[i] && !r_pend[i])
          r_pend[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_i[i] && !r_pend[i]) begin
        r_paddr[i] <= req_addr_i[i*ADDR_W +: ADDR_W];
        r_plen[i]  <= req_len_i[i*8 +: 8];
      end
    end
    if (w_grant) begin
      r_tag_id[r_wr_ptr]  <= w_win;
      r_tag_len[r_wr_ptr] <= r_plen[w_win];
    end
  end

  // AR channel: a new grant may reload the register in the handshake cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_arvalid <= 1'b0;
      m_araddr  <= '0;
      m_arlen   <= '0;
      grant_o   <= '0;
      r_rr_ptr  <= '0;
    end else begin
      grant_o <= '0;
      if (w_grant) begin
        m_arvalid      <= 1'b1;
        m_araddr       <= r_paddr[w_win];
        m_arlen        <= r_plen[w_win];
        grant_o[w_win] <= 1'b1;
        r_rr_ptr       <= (w_win == IW'(NUM_REQ - 1)) ? '0 : w_win + IW'(1);
      end else if (m_arready) begin
        m_arvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_outst    <= '0;
      r_tag_disc <= '0;
    end else begin
      if (w_grant) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_grant, w_pop})
        2'b10:   r_outst <= r_outst + CW'(1);
        2'b01:   r_outst <= r_outst - CW'(1);
        default: r_outst <= r_outst;
      endcase
      for (int k = 0; k < MAX_OUTST; k++) begin
        if (flush_i[r_tag_id[k]]) r_tag_disc[k] <= 1'b1;
      end
      if (w_grant) r_tag_disc[r_wr_ptr] <= flush_i[w_win];
    end
  end

  // R channel: beats are routed to the head tag's owner, discarded ones are muted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_rready   <= 1'b0;
      valid_o    <= '0;
      rdata_o    <= '0;
      r_beat_cnt <= '0;
      err_o      <= 1'b0;
    end else begin
      m_rready <= 1'b1;
      valid_o  <= '0;
      if (w_beat) begin
        if (!w_has_tag) begin
          err_o <= 1'b1;
        end else begin
          rdata_o            <= m_rdata;
          valid_o[w_head_id] <= !w_head_disc;
          if (m_rlast) begin
            r_beat_cnt <= '0;
            if (r_beat_cnt != {1'b0, w_head_len}) err_o <= 1'b1;
          end else begin
            if (r_beat_cnt != 9'h1FF) r_beat_cnt <= r_beat_cnt + 9'd1;
            if (r_beat_cnt > {1'b0, w_head_len}) err_o <= 1'b1;
          end
        end
      end
    end
  end

endmodule
